tone_divider_bank: RTL and testbench
====================================

Name: tone_divider_bank

Overview:
Bank of N_CH independent programmable clock/tone dividers running off the single 50 MHz system clock. Each channel generates a square wave whose period is given by a runtime divisor. Divisor changes are glitch-free: a new divisor is held in a shadow register and applied only at the channel's period boundary. The bank feeds the pitch/tone output path, with one channel per voice, and raises a per-channel period tick for downstream sequencing.

Parameters:
N_CH, 4, number of independent divider channels (1..16)
CNT_W, 32, width of divisor, duty and internal counters
CH_W, $clog2(N_CH) (min 1), width of channel select

Ports:
clk  in  1  system clock, 50 MHz
reset  in  1  synchronous, active-high
ch_en  in  N_CH  per-channel run enable, level
cfg_valid  in  1  one-cycle config write strobe; always accepted
cfg_ch  in  CH_W  target channel of write
cfg_divisor  in  CNT_W  new period in clk cycles
cfg_duty  in  CNT_W  high cycles per period (only with TONE_DUTY_EN)
clk_out  out  N_CH  per-channel divided square wave, registered
period_tick  out  N_CH  one-cycle pulse per channel at period wrap, registered
pending  out  N_CH  shadow divisor loaded, not yet applied

Behaviour:
- Reset: count=0, active_div=0, shadow=0, pending=0, clk_out=0, period_tick=0 for all channels.
- Channel is live when ch_en[i]=1 and active_div>=2. When it is not live: count held at 0, clk_out[i]=0, period_tick[i]=0.
- Write: when cfg_valid is high, the shadow of cfg_ch is loaded and pending[cfg_ch] is set on the next cycle. A second write before application overwrites the shadow; the last write wins. A cfg_ch value >= N_CH is ignored.
- Apply: if the channel is not live, the shadow is copied to active_div on the cycle after pending is set, and pending clears. If the channel is live, the copy happens on the wrap cycle (count==active_div-1): count<=0, active_div<=shadow, pending clears.
- Wrap and apply in the same cycle as a new cfg write to that channel: the write lands in the shadow and pending stays 1. The old shadow is applied now; the new shadow is applied at the next wrap.
- Counter: count increments by 1 each live cycle and wraps to 0 at active_div-1. Comparisons are unsigned CNT_W. No overflow is possible because active_div <= 2^CNT_W-1.
- Output: clk_out[i] <= (count < high_i), registered, so it lags count by 1 cycle. Without duty, high_i = active_div>>1 (floor). An odd divisor gives a low phase one cycle longer than the high phase.
- period_tick[i] <= 1 on the cycle after count==active_div-1 while live. Otherwise 0.
- ch_en deassert mid-period: the next cycle has count=0 and clk_out=0. Re-enable: count runs from 0, first clk_out=1 appears 1 cycle after enable (for high>=1).
- reset mid-operation overrides everything, including a cfg_valid in the same cycle.
- Channels are fully independent; there are no cross-channel interactions.

Optional Feature:
TONE_DUTY_EN: when defined, cfg_duty is present and shadowed alongside the divisor, and both apply atomically at the same point. high_i = min(active_duty, active_div), so duty>=div gives a constant-high output and duty=0 gives a constant-low output (ticks still pulse). When undefined, the cfg_duty port is absent and duty is fixed at floor(div/2).

Decomposition:
- Package tone_divider_pkg: CNT_W default, BASE_CLK_HZ=50_000_000, MIN_DIV=2, and a typedef for the channel config struct {divisor, duty}.
- Sub-module tone_divider_channel holds one channel's counter, shadow, pending and output registers. The bank generates N_CH instances and decodes cfg_ch to a per-channel write strobe.

Test Plan:
- Reset, ch_en=1, write ch0 div=4: pending[0] pulses 1 cycle, then clk_out[0] is 1,1,0,0 repeating; period_tick[0] fires every 4 cycles.
- ch1 live at div=10; write div=6 at count=3: old period completes (10 cycles total), then 6-cycle periods begin; clk_out has no runt pulse.
- Write div=5 (no duty): high 2 cycles, low 3 cycles. Write div=1 or 0: clk_out stays 0, period_tick stays 0.
- Two writes to ch2 (div=8 then div=12) before wrap: only 12 is applied. A write coinciding with the wrap cycle: old shadow applied, new pending=1, applied at the next wrap.
- ch_en[3] dropped mid-high phase: next cycle clk_out[3]=0. Re-enabled: output restarts from count 0. Reset asserted with cfg_valid=1 in the same cycle: all outputs 0, pending 0.
- TONE_DUTY_EN: div=10, duty=3 gives 3 high / 7 low. duty=10 gives constant high. duty=0 gives constant low with ticks every 10 cycles.

Source files
------------

// File: rtl/tone_divider_pkg.sv
// Shared constants and types for the tone divider bank.
// The duty-cycle feature is compiled in with TONE_DUTY_EN.
package tone_divider_pkg;

  localparam int CNT_W_DEFAULT = 32;
  localparam int BASE_CLK_HZ   = 50_000_000;
  localparam int MIN_DIV       = 2;

  typedef struct packed {
    logic [CNT_W_DEFAULT-1:0] divisor;
    logic [CNT_W_DEFAULT-1:0] duty;
  } ch_cfg_t;

  // Divisor that produces the requested tone frequency from the system clock.
  function automatic int unsigned tone_divisor(input int unsigned freq_hz);
    if (freq_hz == 0) return 0;
    return BASE_CLK_HZ / freq_hz;
  endfunction

endpackage

// File: rtl/tone_divider_channel.sv
// One divider channel: period counter, shadowed divisor, square wave and tick.
// With TONE_DUTY_EN a duty value is shadowed and applied together with the divisor.
module tone_divider_channel
  import tone_divider_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  input  logic             i_wr,
  input  logic [CNT_W-1:0] i_divisor,
`ifdef TONE_DUTY_EN
  input  logic [CNT_W-1:0] i_duty,
`endif
  output logic             o_clk_out,
  output logic             o_tick,
  output logic             o_pending
);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_active_div;
  logic [CNT_W-1:0] r_shadow_div;
  logic             r_pending;
  logic             r_clk_out;
  logic             r_tick;
`ifdef TONE_DUTY_EN
  logic [CNT_W-1:0] r_active_duty;
  logic [CNT_W-1:0] r_shadow_duty;
`endif

  logic             w_live;
  logic             w_wrap;
  logic             w_apply;
  logic [CNT_W-1:0] w_high;

  // An idle channel takes a new setting at once; a running one only at its wrap.
  always_comb begin
    w_live  = i_en && (r_active_div >= CNT_W'(MIN_DIV));
    w_wrap  = w_live && (r_count == r_active_div - CNT_W'(1));
    w_apply = r_pending && (!w_live || w_wrap);
`ifdef TONE_DUTY_EN
    w_high  = (r_active_duty < r_active_div) ? r_active_duty : r_active_div;
`else
    w_high  = r_active_div >> 1;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count       <= '0;
      r_active_div  <= '0;
      r_shadow_div  <= '0;
      r_pending     <= 1'b0;
      r_clk_out     <= 1'b0;
      r_tick        <= 1'b0;
`ifdef TONE_DUTY_EN
      r_active_duty <= '0;
      r_shadow_duty <= '0;
`endif
    end else begin
      if (i_wr) begin
        r_shadow_div  <= i_divisor;
`ifdef TONE_DUTY_EN
        r_shadow_duty <= i_duty;
`endif
      end
      if (w_apply) begin
        r_active_div  <= r_shadow_div;
`ifdef TONE_DUTY_EN
        r_active_duty <= r_shadow_duty;
`endif
      end
      // A write landing on the apply cycle keeps the new value pending.
      if (i_wr) begin
        r_pending <= 1'b1;
      end else if (w_apply) begin
        r_pending <= 1'b0;
      end
      if (!w_live || w_wrap) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + CNT_W'(1);
      end
      r_clk_out <= w_live && (r_count < w_high);
      r_tick    <= w_wrap;
    end
  end

  assign o_clk_out = r_clk_out;
  assign o_tick    = r_tick;
  assign o_pending = r_pending;

endmodule

// File: rtl/tone_divider_bank.sv
// Bank of independent tone dividers, one per voice, sharing one config port.
// Define TONE_DUTY_EN to add the cfg_duty port and programmable duty cycle.
module tone_divider_bank
  import tone_divider_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CNT_W = CNT_W_DEFAULT,
  parameter int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_CH-1:0]  ch_en,
  input  logic             cfg_valid,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_divisor,
`ifdef TONE_DUTY_EN
  input  logic [CNT_W-1:0] cfg_duty,
`endif
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  period_tick,
  output logic [N_CH-1:0]  pending
);

  logic [N_CH-1:0] w_wr;

  // Channel select values with no matching channel simply hit no strobe.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign w_wr[i] = cfg_valid && (cfg_ch == CH_W'(i));

    tone_divider_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .i_en      (ch_en[i]),
      .i_wr      (w_wr[i]),
      .i_divisor (cfg_divisor),
`ifdef TONE_DUTY_EN
      .i_duty    (cfg_duty),
`endif
      .o_clk_out (clk_out[i]),
      .o_tick    (period_tick[i]),
      .o_pending (pending[i])
    );
  end

endmodule

// File: tb/tb_tone_divider_bank.sv
// Scoreboard bench for tone_divider_bank: expected per-cycle outputs are queued
// from the intended waveform shapes and popped as the DUT advances.
module tb_tone_divider_bank;
  import tone_divider_pkg::*;

  localparam int N_CH  = 4;
  localparam int CNT_W = CNT_W_DEFAULT;
  localparam int CH_W  = 2;

  typedef struct {
    int              c;
    bit              isEn;
    int              ch;
    ch_cfg_t         cfg;
    logic [N_CH-1:0] en;
  } stim_t;

  typedef struct {
    bit clk;
    bit tick;
    bit pend;
  } exp_t;

  logic             clk;
  logic             reset;
  logic [N_CH-1:0]  ch_en;
  logic             cfg_valid;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_divisor;
`ifdef TONE_DUTY_EN
  logic [CNT_W-1:0] cfg_duty;
`endif
  logic [N_CH-1:0]  clk_out;
  logic [N_CH-1:0]  period_tick;
  logic [N_CH-1:0]  pending;

  stim_t stim_q[$];
  exp_t  exp_q[$];
  int    checks;
  int    fails;

  tone_divider_bank #(
    .N_CH (N_CH),
    .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ch_en      (ch_en),
    .cfg_valid  (cfg_valid),
    .cfg_ch     (cfg_ch),
    .cfg_divisor(cfg_divisor),
`ifdef TONE_DUTY_EN
    .cfg_duty   (cfg_duty),
`endif
    .clk_out    (clk_out),
    .period_tick(period_tick),
    .pending    (pending)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic addWrite(input int c, input int ch, input int dv, input int dt);
    stim_t s;
    s.c = c;
    s.isEn = 1'b0;
    s.ch = ch;
    s.cfg.divisor = CNT_W'(dv);
    s.cfg.duty = CNT_W'(dt);
    s.en = '0;
    stim_q.push_back(s);
  endtask

  task automatic addEn(input int c, input logic [N_CH-1:0] en);
    stim_t s;
    s.c = c;
    s.isEn = 1'b1;
    s.ch = 0;
    s.cfg = '0;
    s.en = en;
    stim_q.push_back(s);
  endtask

  task automatic pushIdle(input int n);
    exp_t e;
    e.clk = 1'b0;
    e.tick = 1'b0;
    e.pend = 1'b0;
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  task automatic pushPeriod(input int d, input int h);
    exp_t e;
    for (int j = 0; j < d; j++) begin
      e.clk = (j < h);
      e.tick = (j == d - 1);
      e.pend = 1'b0;
      exp_q.push_back(e);
    end
  endtask

  task automatic markPending(input int lo, input int hi);
    exp_t e;
    for (int i = lo; i <= hi; i++) begin
      e = exp_q[i];
      e.pend = 1'b1;
      exp_q[i] = e;
    end
  endtask

  task automatic driveCycle(input int c);
    cfg_valid = 1'b0;
    foreach (stim_q[i]) begin
      if (stim_q[i].c == c) begin
        if (stim_q[i].isEn) begin
          ch_en = stim_q[i].en;
        end else begin
          cfg_valid = 1'b1;
          cfg_ch = CH_W'(stim_q[i].ch);
          cfg_divisor = stim_q[i].cfg.divisor;
`ifdef TONE_DUTY_EN
          cfg_duty = stim_q[i].cfg.duty;
`endif
        end
      end
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    cfg_valid = 1'b0;
    ch_en = '1;
    step();
    step();
    reset = 1'b0;
    stim_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ch_en = '1;
    cfg_valid = 1'b1;
    cfg_ch = '0;
    cfg_divisor = CNT_W'(4);
`ifdef TONE_DUTY_EN
    cfg_duty = CNT_W'(2);
`endif
    step();
    checks++;
    if (clk_out !== '0) begin
      fails++;
      $display("[TB] FAIL reset_clk_out got=%b expected=0000", clk_out);
    end
    checks++;
    if (period_tick !== '0) begin
      fails++;
      $display("[TB] FAIL reset_tick got=%b expected=0000", period_tick);
    end
    checks++;
    if (pending !== '0) begin
      fails++;
      $display("[TB] FAIL reset_pending got=%b expected=0000", pending);
    end
    reset = 1'b0;
    cfg_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({clk_out, pending} !== '0) begin
        fails++;
        $display("[TB] FAIL reset_write_dropped cyc=%0d got clk/pend=%b expected 0", i, {clk_out, pending});
      end
    end
  endtask

  task automatic test_div4();
    exp_t e;
    doReset();
    addWrite(0, 0, 4, 2);
    pushIdle(2);
    markPending(0, 0);
    for (int p = 0; p < 3; p++) pushPeriod(4, 2);
    for (int c = 0; exp_q.size() > 0; c++) begin
      driveCycle(c);
      step();
      e = exp_q.pop_front();
      checks++;
      if ({clk_out[0], period_tick[0], pending[0]} !== {e.clk, e.tick, e.pend}) begin
        fails++;
        $display("[TB] FAIL div4 c=%0d got clk/tick/pend=%b expected %b", c,
                 {clk_out[0], period_tick[0], pending[0]}, {e.clk, e.tick, e.pend});
      end
    end
  endtask

  task automatic test_retune();
    exp_t e;
    doReset();
    addWrite(0, 1, 10, 5);
    addWrite(5, 1, 6, 3);
    pushIdle(2);
    pushPeriod(10, 5);
    pushPeriod(6, 3);
    pushPeriod(6, 3);
    markPending(0, 0);
    markPending(5, 10);
    for (int c = 0; exp_q.size() > 0; c++) begin
      driveCycle(c);
      step();
      e = exp_q.pop_front();
      checks++;
      if ({clk_out[1], period_tick[1], pending[1]} !== {e.clk, e.tick, e.pend}) begin
        fails++;
        $display("[TB] FAIL retune c=%0d got clk/tick/pend=%b expected %b", c,
                 {clk_out[1], period_tick[1], pending[1]}, {e.clk, e.tick, e.pend});
      end
    end
  endtask

  task automatic test_odd_and_small();
    exp_t e;
    doReset();
    addWrite(0, 0, 5, 2);
    pushIdle(2);
    markPending(0, 0);
    for (int p = 0; p < 3; p++) pushPeriod(5, 2);
    for (int c = 0; exp_q.size() > 0; c++) begin
      driveCycle(c);
      step();
      e = exp_q.pop_front();
      checks++;
      if ({clk_out[0], period_tick[0], pending[0]} !== {e.clk, e.tick, e.pend}) begin
        fails++;
        $display("[TB] FAIL odd_div5 c=%0d got clk/tick/pend=%b expected %b", c,
                 {clk_out[0], period_tick[0], pending[0]}, {e.clk, e.tick, e.pend});
      end
    end
    doReset();
    addWrite(0, 2, 1, 0);
    addWrite(5, 2, 0, 0);
    addWrite(10, 2, 2, 1);
    pushIdle(12);
    for (int p = 0; p < 3; p++) pushPeriod(2, 1);
    markPending(0, 0);
    markPending(5, 5);
    markPending(10, 10);
    for (int c = 0; exp_q.size() > 0; c++) begin
      driveCycle(c);
      step();
      e = exp_q.pop_front();
      checks++;
      if ({clk_out[2], period_tick[2], pending[2]} !== {e.clk, e.tick, e.pend}) begin
        fails++;
        $display("[TB] FAIL small_div c=%0d got clk/tick/pend=%b expected %b", c,
                 {clk_out[2], period_tick[2], pending[2]}, {e.clk, e.tick, e.pend});
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    doReset();
    addWrite(0, 2, 4, 2);
    addWrite(3, 2, 8, 4);
    addWrite(4, 2, 12, 6);
    addWrite(10, 2, 10, 5);
    addWrite(17, 2, 6, 3);
    pushIdle(2);
    pushPeriod(4, 2);
    pushPeriod(12, 6);
    pushPeriod(10, 5);
    pushPeriod(6, 3);
    pushPeriod(6, 3);
    markPending(0, 0);
    markPending(3, 4);
    markPending(10, 26);
    for (int c = 0; exp_q.size() > 0; c++) begin
      driveCycle(c);
      step();
      e = exp_q.pop_front();
      checks++;
      if ({clk_out[2], period_tick[2], pending[2]} !== {e.clk, e.tick, e.pend}) begin
        fails++;
        $display("[TB] FAIL back_to_back c=%0d got clk/tick/pend=%b expected %b", c,
                 {clk_out[2], period_tick[2], pending[2]}, {e.clk, e.tick, e.pend});
      end
    end
  endtask

  task automatic test_enable();
    exp_t e;
    doReset();
    addWrite(0, 3, 8, 4);
    addEn(12, 4'b0111);
    addEn(16, 4'b1111);
    pushIdle(2);
    pushPeriod(8, 4);
    e.clk = 1'b1;
    e.tick = 1'b0;
    e.pend = 1'b0;
    exp_q.push_back(e);
    exp_q.push_back(e);
    pushIdle(4);
    pushPeriod(8, 4);
    pushPeriod(8, 4);
    markPending(0, 0);
    for (int c = 0; exp_q.size() > 0; c++) begin
      driveCycle(c);
      step();
      e = exp_q.pop_front();
      checks++;
      if ({clk_out[3], period_tick[3], pending[3]} !== {e.clk, e.tick, e.pend}) begin
        fails++;
        $display("[TB] FAIL enable c=%0d got clk/tick/pend=%b expected %b", c,
                 {clk_out[3], period_tick[3], pending[3]}, {e.clk, e.tick, e.pend});
      end
    end
  endtask

  task automatic test_reset_mid();
    doReset();
    addWrite(0, 0, 4, 2);
    for (int c = 0; c < 8; c++) begin
      driveCycle(c);
      step();
    end
    reset = 1'b1;
    cfg_valid = 1'b1;
    cfg_ch = CH_W'(1);
    cfg_divisor = CNT_W'(6);
    step();
    checks++;
    if ({clk_out, period_tick, pending} !== '0) begin
      fails++;
      $display("[TB] FAIL reset_mid got clk/tick/pend=%b expected 0", {clk_out, period_tick, pending});
    end
    reset = 1'b0;
    cfg_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({clk_out, period_tick, pending} !== '0) begin
        fails++;
        $display("[TB] FAIL reset_mid_after cyc=%0d got=%b expected 0", i, {clk_out, period_tick, pending});
      end
    end
  endtask

`ifdef TONE_DUTY_EN
  task automatic test_duty();
    exp_t e;
    int   duties[3];
    duties = '{3, 10, 0};
    for (int k = 0; k < 3; k++) begin
      doReset();
      addWrite(0, 0, 10, duties[k]);
      pushIdle(2);
      markPending(0, 0);
      pushPeriod(10, duties[k]);
      pushPeriod(10, duties[k]);
      for (int c = 0; exp_q.size() > 0; c++) begin
        driveCycle(c);
        step();
        e = exp_q.pop_front();
        checks++;
        if ({clk_out[0], period_tick[0], pending[0]} !== {e.clk, e.tick, e.pend}) begin
          fails++;
          $display("[TB] FAIL duty%0d c=%0d got clk/tick/pend=%b expected %b", duties[k], c,
                   {clk_out[0], period_tick[0], pending[0]}, {e.clk, e.tick, e.pend});
        end
      end
    end
  endtask
`endif

  initial begin
    checks = 0;
    fails = 0;
    reset = 1'b1;
    ch_en = '0;
    cfg_valid = 1'b0;
    cfg_ch = '0;
    cfg_divisor = '0;
`ifdef TONE_DUTY_EN
    cfg_duty = '0;
`endif
    test_reset();
    test_div4();
    test_retune();
    test_odd_and_small();
    test_back_to_back();
    test_enable();
    test_reset_mid();
`ifdef TONE_DUTY_EN
    test_duty();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
